vector_alu_pipe: RTL and testbench
==================================

Name: vector_alu_pipe

Overview:
- Parametrised, pipelined integer vector ALU: NUM_LANES lanes of ELEM_W bits, per-lane masking, element-wise and reduction ops.
- valid/ready handshakes on both sides; fixed LATENCY with back-pressure stall; tag carried alongside each op.
- Sits between the scoreboard/issue stage and vector register writeback; replaces the single-cycle VALU port.

Parameters:
- NUM_LANES, 16, number of vector elements per operation (>=2, power of two)
- ELEM_W, 16, bits per element (8..32)
- LATENCY, 3, cycles from input handshake to out_valid (>=1)
- TAG_W, 5, width of opaque destination tag
- MASK_ZERO, 0, masked-off lanes output 0 when 1; pass vdat1 lane when 0

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept this cycle
- vop  in  4  opcode
- vdat1  in  NUM_LANES*ELEM_W  operand A, lane i = bits [i*ELEM_W +: ELEM_W]
- vdat2  in  NUM_LANES*ELEM_W  operand B
- vmask  in  NUM_LANES  lane enable, 1 = active
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  NUM_LANES*ELEM_W  result vector
- out_tag  out  TAG_W  tag of the result
- error  out  1  illegal opcode on this result

Behaviour:
- One clock CLK; reset synchronous, active-low (nRST=0 sampled at a CLK edge). All stage valids clear; out_valid=0, result=0, out_tag=0, error=0. in_ready=1 during and after reset. In-flight ops are discarded by a mid-operation reset.
- Opcodes (signed two's complement, results mod 2^ELEM_W): 0 ADD, 1 SUB (A-B), 2 MUL (low ELEM_W bits), 3 MIN, 4 MAX, 5 AND, 6 OR, 7 XOR, 8 REDSUM. Opcodes 9-15 are illegal.
- Element-wise ops: lane i computes only when vmask[i]=1. Otherwise result lane = 0 if MASK_ZERO=1, else vdat1 lane.
- REDSUM: lane 0 = wrap-around sum of vdat1 lanes with vmask=1; lanes 1..N-1 = 0 regardless of MASK_ZERO. All-zero mask gives lane 0 = 0.
- Illegal opcode: result all 0, error=1, out_tag still carried, op still consumes a slot.
- Compute happens in stage 1; stages 2..LATENCY are register stages. REDSUM may be split as an adder tree across stages, but total latency is always exactly LATENCY.
- Handshake: input accepted when in_valid & in_ready. Result is transferred when out_valid & out_ready. result, out_tag and error are held stable while out_valid=1 and out_ready=0.
- Stall: stall = out_valid & ~out_ready. When stalled, the whole pipeline freezes and in_ready=0 (combinational from out_ready). Otherwise in_ready=1 and all stages advance.
- Throughput is one op per cycle with out_ready held high. No bubbles are inserted; bubbles in the input stream propagate as invalid stages.
- Latency: an op accepted at edge k gives out_valid=1 after edge k+LATENCY-1 (visible in cycle k+LATENCY), assuming no stall.
- Simultaneous output accept and input accept in the same cycle is legal and must not drop or duplicate ops.
- vop, vdat and in_tag are sampled only on handshake. Values while in_valid=0 are ignored.

Test Plan:
- Reset, then ADD with all lanes A=0x7FFF, B=0x0001, vmask=all-ones, tag=3 -> after LATENCY=3 cycles every lane = 0x8000, out_tag=3, error=0.
- MIN/MAX with A lane=0xFFFF (-1), B lane=0x0002, vmask=0x00FF, MASK_ZERO=0 -> MIN gives lanes 0-7 = 0xFFFF, MAX gives lanes 0-7 = 0x0002; lanes 8-15 = A. Rerun with MASK_ZERO=1 -> lanes 8-15 = 0.
- REDSUM with A lane i = i+1, vmask=0xAAAA -> lane 0 = 2+4+...+16 = 72 = 0x0048, other lanes 0. vmask=0 -> all lanes 0.
- Back-to-back 5 ops with out_ready held low from cycle 4 for 3 cycles -> in_ready=0 during the stall, outputs stable, all 5 results delivered in order with correct tags, no loss or duplication.
- vop=12 -> result 0, error=1, tag preserved. Following legal MUL with 0x0100*0x0100 -> lane = 0x0000 (wrap), error=0.
- nRST asserted with 2 ops in flight -> next cycle out_valid=0; no stale result appears after reset releases.

Source files
------------

// File: rtl/vector_alu_pipe.sv
// Pipelined integer vector ALU with per-lane masking, reduction sum and a tag sideband.
// Stage 1 computes, stages 2..LATENCY only carry results; a stalled output freezes every stage.
module vector_alu_pipe #(
  parameter int NUM_LANES = 16,
  parameter int ELEM_W    = 16,
  parameter int LATENCY   = 3,
  parameter int TAG_W     = 5,
  parameter bit MASK_ZERO = 1'b0
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  vop,
  input  logic [NUM_LANES*ELEM_W-1:0] vdat1,
  input  logic [NUM_LANES*ELEM_W-1:0] vdat2,
  input  logic [NUM_LANES-1:0]        vmask,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES*ELEM_W-1:0] result,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        error
);

  localparam int VEC_W = NUM_LANES * ELEM_W;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_MIN    = 4'd3;
  localparam logic [3:0] OP_MAX    = 4'd4;
  localparam logic [3:0] OP_AND    = 4'd5;
  localparam logic [3:0] OP_OR     = 4'd6;
  localparam logic [3:0] OP_XOR    = 4'd7;
  localparam logic [3:0] OP_REDSUM = 4'd8;

  // Element-wise lane operation; all arithmetic wraps modulo 2^ELEM_W.
  function automatic logic signed [ELEM_W-1:0] lane_op(
    input logic [3:0]               op,
    input logic signed [ELEM_W-1:0] a,
    input logic signed [ELEM_W-1:0] b
  );
    logic signed [ELEM_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_MIN:  r = (a < b) ? a : b;
      OP_MAX:  r = (a > b) ? a : b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic             stall;
  logic [VEC_W-1:0] res_p0;
  logic             err_p0;
  logic [ELEM_W-1:0] redsum_p0;

  logic [VEC_W-1:0] res_pn [LATENCY];
  logic [TAG_W-1:0] tag_pn [LATENCY];
  logic             err_pn [LATENCY];
  logic             vld_pn [LATENCY];

  assign stall    = vld_pn[LATENCY-1] & ~out_ready;
  assign in_ready = ~stall | ~nRST;

  // ---- stage 0 -> 1: compute ----
  always_comb begin
    res_p0    = '0;
    err_p0    = 1'b0;
    redsum_p0 = '0;
    if (vop > OP_REDSUM) begin
      err_p0 = 1'b1;
    end else if (vop == OP_REDSUM) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (vmask[i]) redsum_p0 = redsum_p0 + vdat1[i*ELEM_W +: ELEM_W];
      end
      res_p0[ELEM_W-1:0] = redsum_p0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (vmask[i])
          res_p0[i*ELEM_W +: ELEM_W] = lane_op(vop, vdat1[i*ELEM_W +: ELEM_W],
                                               vdat2[i*ELEM_W +: ELEM_W]);
        else if (!MASK_ZERO)
          res_p0[i*ELEM_W +: ELEM_W] = vdat1[i*ELEM_W +: ELEM_W];
      end
    end
  end

  // ---- stages 1..LATENCY: valid chain (control, reset) ----
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < LATENCY; i++) vld_pn[i] <= 1'b0;
    end else if (!stall) begin
      vld_pn[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld_pn[i] <= vld_pn[i-1];
    end
  end

  // ---- stages 1..LATENCY: data registers (no reset, frozen on stall) ----
  always_ff @(posedge CLK) begin
    if (!stall) begin
      res_pn[0] <= res_p0;
      tag_pn[0] <= in_tag;
      err_pn[0] <= err_p0;
      for (int i = 1; i < LATENCY; i++) begin
        res_pn[i] <= res_pn[i-1];
        tag_pn[i] <= tag_pn[i-1];
        err_pn[i] <= err_pn[i-1];
      end
    end
  end

  // Outputs read as zero whenever no valid result is presented, including after reset.
  assign out_valid = vld_pn[LATENCY-1];
  assign result    = out_valid ? res_pn[LATENCY-1] : '0;
  assign out_tag   = out_valid ? tag_pn[LATENCY-1] : '0;
  assign error     = out_valid & err_pn[LATENCY-1];

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench for vector_alu_pipe: two instances (MASK_ZERO=0 and 1) share stimulus,
// expected results come from a lane-by-lane integer model and are popped by a monitor.
module tb_vector_alu_pipe;
  localparam int NL = 16;
  localparam int EW = 16;
  localparam int VW = NL * EW;
  localparam int TW = 5;
  localparam int LAT = 3;

  typedef logic [VW-1:0] vec_t;
  typedef logic [NL-1:0] mask_t;
  typedef logic [TW-1:0] tag_t;
  typedef struct packed { vec_t res; tag_t tag; logic err; } exp_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [3:0] vop = '0;
  vec_t vdat1 = '0, vdat2 = '0;
  mask_t vmask = '0;
  tag_t in_tag = '0;

  logic in_ready0, in_ready1, ov0, ov1, err0, err1;
  vec_t res0, res1;
  tag_t tag0, tag1;

  vector_alu_pipe #(.NUM_LANES(NL), .ELEM_W(EW), .LATENCY(LAT), .TAG_W(TW), .MASK_ZERO(1'b0)) dut0 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready0), .vop(vop),
    .vdat1(vdat1), .vdat2(vdat2), .vmask(vmask), .in_tag(in_tag), .out_valid(ov0),
    .out_ready(out_ready), .result(res0), .out_tag(tag0), .error(err0));

  vector_alu_pipe #(.NUM_LANES(NL), .ELEM_W(EW), .LATENCY(LAT), .TAG_W(TW), .MASK_ZERO(1'b1)) dut1 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready1), .vop(vop),
    .vdat1(vdat1), .vdat2(vdat2), .vmask(vmask), .in_tag(in_tag), .out_valid(ov1),
    .out_ready(out_ready), .result(res1), .out_tag(tag1), .error(err1));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  int low_cnt = 0;
  bit rand_mode = 1'b0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic per lane, truncated to the element width.
  function automatic exp_t model(input logic [3:0] op, input vec_t a, input vec_t b,
                                 input mask_t m, input tag_t t, input bit mz);
    exp_t e;
    int x, y, z, s;
    e.res = '0;
    e.tag = t;
    e.err = (op > 4'd8);
    if (op == 4'd8) begin
      s = 0;
      for (int i = 0; i < NL; i++)
        if (m[i]) s += int'($signed(a[i*EW +: EW]));
      e.res[EW-1:0] = EW'(s);
    end else if (op < 4'd8) begin
      for (int i = 0; i < NL; i++) begin
        x = int'($signed(a[i*EW +: EW]));
        y = int'($signed(b[i*EW +: EW]));
        case (op)
          4'd0: z = x + y;
          4'd1: z = x - y;
          4'd2: z = x * y;
          4'd3: z = (x < y) ? x : y;
          4'd4: z = (x > y) ? x : y;
          4'd5: z = x & y;
          4'd6: z = x | y;
          4'd7: z = x ^ y;
          default: z = 0;
        endcase
        if (m[i]) e.res[i*EW +: EW] = EW'(z);
        else if (!mz) e.res[i*EW +: EW] = a[i*EW +: EW];
      end
    end
    return e;
  endfunction

  task automatic send(input logic [3:0] op, input vec_t a, input vec_t b,
                      input mask_t m, input tag_t t);
    int guard = 0;
    bit ok = 1'b0;
    @(negedge CLK);
    in_valid = 1'b1; vop = op; vdat1 = a; vdat2 = b; vmask = m; in_tag = t;
    forever begin
      #2;
      if (in_ready0) begin ok = 1'b1; break; end
      @(negedge CLK);
      guard++;
      if (guard > 50) break;
    end
    if (ok) begin
      q0.push_back(model(op, a, b, m, t, 1'b0));
      q1.push_back(model(op, a, b, m, t, 1'b1));
      @(posedge CLK);
      #1;
    end else begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
      in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge CLK);
    in_valid = 1'b0;
    vop = 4'($urandom);
    vdat1 = {8{$urandom}};
    vdat2 = {8{$urandom}};
    vmask = NL'($urandom);
    in_tag = TW'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 300) begin
      @(negedge CLK);
      in_valid = 1'b0;
      guard++;
    end
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: pending %0d/%0d expected 0", q0.size(), q1.size());
    end
  endtask

  // out_ready driver: forced-low window, else random or always high.
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (low_cnt > 0) begin
        out_ready = 1'b0;
        low_cnt--;
      end else begin
        out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops expectations on each output transfer, checks hold-while-stalled.
  initial begin
    exp_t e;
    logic prev_stall = 1'b0;
    vec_t pr0, pr1;
    tag_t pt0;
    logic pe0;
    forever begin
      @(negedge CLK);
      #3;
      if (!nRST || !mon_en) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready", VW'(in_ready0), VW'(!(ov0 && !out_ready)));
        if (prev_stall) begin
          chk("hold_res0", res0, pr0);
          chk("hold_res1", res1, pr1);
          chk("hold_tag_err", VW'({tag0, err0}), VW'({pt0, pe0}));
        end
        if (ov0 && out_ready) begin
          if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected0: out_valid 1 tag %0h expected no output", tag0);
          end else begin
            e = q0.pop_front();
            chk("res0", res0, e.res);
            chk("tag_err0", VW'({tag0, err0}), VW'({e.tag, e.err}));
          end
        end
        if (ov1 && out_ready) begin
          if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected1: out_valid 1 tag %0h expected no output", tag1);
          end else begin
            e = q1.pop_front();
            chk("res1", res1, e.res);
            chk("tag_err1", VW'({tag1, err1}), VW'({e.tag, e.err}));
          end
        end
        prev_stall = ov0 && !out_ready;
        pr0 = res0; pr1 = res1; pt0 = tag0; pe0 = err0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t a, b;
    int n;
    logic [3:0] op;

    // Reset state
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", VW'({ov0, ov1}), VW'(0));
    chk("rst_result", res0 | res1, '0);
    chk("rst_tag_err", VW'({tag0, err0, tag1, err1}), VW'(0));
    chk("rst_in_ready", VW'({in_ready0, in_ready1}), VW'(2'b11));
    nRST = 1'b1;
    mon_en = 1'b1;

    // ADD overflow wrap with latency measurement
    send(4'd0, {NL{16'h7FFF}}, {NL{16'h0001}}, '1, 5'd3);
    n = 0;
    do begin
      @(negedge CLK);
      in_valid = 1'b0;
      n++;
    end while (!ov0 && n < 20);
    chk("add_latency", VW'(n), VW'(LAT));
    chk("add_result", res0, {NL{16'h8000}});
    chk("add_tag", VW'({tag0, err0}), VW'({5'd3, 1'b0}));
    drain();

    // MIN / MAX with partial mask (both MASK_ZERO variants compared)
    send(4'd3, {NL{16'hFFFF}}, {NL{16'h0002}}, 16'h00FF, 5'd4);
    send(4'd4, {NL{16'hFFFF}}, {NL{16'h0002}}, 16'h00FF, 5'd5);
    drain();

    // REDSUM: alternate lanes, then empty mask
    for (int i = 0; i < NL; i++) a[i*EW +: EW] = EW'(i + 1);
    send(4'd8, a, {8{$urandom}}, 16'hAAAA, 5'd6);
    send(4'd8, a, {8{$urandom}}, 16'h0000, 5'd7);
    drain();

    // Illegal opcode then wrapping MUL
    send(4'd12, {8{$urandom}}, {8{$urandom}}, '1, 5'd9);
    send(4'd2, {NL{16'h0100}}, {NL{16'h0100}}, '1, 5'd10);
    drain();

    // Five back-to-back ops with a three-cycle output stall starting in cycle 4
    fork
      begin repeat (4) @(negedge CLK); low_cnt = 3; end
    join_none
    for (int k = 0; k < 5; k++)
      send(4'(k), {8{$urandom}}, {8{$urandom}}, NL'($urandom), TW'(k + 16));
    drain();

    // Reset with two ops in flight: nothing may emerge afterwards
    send(4'd0, {8{$urandom}}, {8{$urandom}}, '1, 5'd20);
    send(4'd1, {8{$urandom}}, {8{$urandom}}, '1, 5'd21);
    @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    low_cnt = 1;
    #2;
    chk("inflight_visible", VW'(ov0), VW'(1));
    chk("rst_in_ready_stalled", VW'(in_ready0), VW'(1));
    @(negedge CLK);
    chk("midrst_out_valid", VW'({ov0, ov1}), VW'(0));
    chk("midrst_tag_err", VW'({tag0, err0}), VW'(0));
    chk("midrst_result", res0, '0);
    q0.delete();
    q1.delete();
    nRST = 1'b1;
    repeat (8) idle();

    // Randomized traffic with random back-pressure and input gaps
    rand_mode = 1'b1;
    for (int k = 0; k < 200; k++) begin
      op = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      a = {8{$urandom}};
      b = {8{$urandom}};
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < NL; i++) a[i*EW +: EW] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      end
      send(op, a, b, NL'($urandom), TW'($urandom));
      if ($urandom_range(0, 4) == 0) idle();
    end
    rand_mode = 1'b0;
    drain();
    repeat (4) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
